imu_channel_integrator: RTL
===========================

# imu_channel_integrator

Parametrised, time-multiplexed per-channel offset-calibrate-and-integrate engine for the IMU. It takes the rate samples that the ADC controller delivers channel by channel. At startup, and on request, it learns a per-channel zero offset by averaging. It then integrates the offset-corrected rate into saturating per-channel angle accumulators. It replaces fixed three-axis gyro-to-degree conversion with NUM_CH channels of configurable width.

## Interface
- NUM_CH, 3: number of integrated channels (≥1).
- SAMPLE_W, 12: unsigned raw sample width.
- ACC_W, 32: signed accumulator/output width per channel (≥ SAMPLE_W+2).
- CAL_SHIFT, 8: calibration averages 2^CAL_SHIFT samples per channel.
- DEADBAND, 4: |delta| ≤ DEADBAND treated as zero (when enabled).

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sample_valid  in  1  one-cycle qualifier for sample_ch/sample_data.
- sample_ch  in  $clog2(NUM_CH) (min 1)  channel index of the sample.
- sample_data  in  SAMPLE_W  unsigned raw rate sample.
- no_external_force  in  1  level, synchronous to clk; its rising edge requests recalibration.
- cal_done  out  1  high while in RUN (offsets valid).
- angle_out  out  NUM_CH*ACC_W  packed signed angles, channel 0 in LSBs.
- angle_valid  out  1  one-cycle pulse when an angle updated.
- angle_ch  out  $clog2(NUM_CH) (min 1)  channel updated by the current angle_valid pulse.

## Operation
- FSM states: CAL and RUN. Reset enters CAL.
- CAL state:
  - Each accepted sample adds into an unsigned per-channel sum of width SAMPLE_W+CAL_SHIFT and increments a per-channel count.
  - Samples for a channel whose count has reached 2^CAL_SHIFT are ignored.
  - When all counts are full: offset[c] = sum[c] >> CAL_SHIFT (truncating), all accumulators are cleared to 0, the FSM goes to RUN, and cal_done goes to 1.
- RUN state:
  - delta = {0,sample} − {0,offset[ch]}, signed SAMPLE_W+1.
  - Deadband applied if enabled.
  - delta is sign-extended to ACC_W and added to acc[ch], saturating to [−2^(ACC_W−1), 2^(ACC_W−1)−1]. A saturated accumulator still moves away from the rail on opposite-sign deltas.
- Recalibration: a rising edge of no_external_force (detected via one internal register) in RUN has the following effects:
  - It moves the FSM to CAL and clears cal_done, sums and counts.
  - Offsets are kept until the new calibration completes.
  - angle_out is held (not cleared); angle_valid is suppressed until RUN.
  - A rising edge while in CAL restarts calibration.
- A sample with sample_ch ≥ NUM_CH is ignored in both states.
- Simultaneous recal edge and sample_valid: the sample is dropped. It is neither integrated nor counted toward calibration.

## Timing
- Full throughput: one sample accepted per cycle, no backpressure.
- Latency: angle_out, angle_valid and angle_ch register on the edge that samples sample_valid, so they are visible one cycle later.
- angle_valid is asserted only in RUN, for accepted samples.
- Calibration completes on the edge that accepts the last required sample: cal_done = 1 and all angles = 0 from the next cycle.
- Recal edge: cal_done = 0 one cycle after no_external_force rises.
- Reset values: cal_done 0, angle_out all 0, angle_valid 0, angle_ch 0, offsets 0, sums/counts 0, FSM CAL.
- Reset mid-operation (including mid-calibration) clears everything immediately and asynchronously.

## Configuration
- IMU_INTEGRATOR_DEADBAND_EN defined: deltas with |delta| ≤ DEADBAND become 0 before accumulation.
- Not defined: raw delta is accumulated and the DEADBAND parameter is unused.

## Structure
- Shared package imu_pkg holds:
  - the state typedef (IMU_CAL, IMU_RUN);
  - default parameter constants;
  - a saturation-limit helper function for ACC_W.
- One sub-module, imu_sat_accumulate: signed ACC_W saturating add of a sign-extended delta. It is instantiated once and time-multiplexed across channels.

## Test plan
Bench configuration: NUM_CH=3, SAMPLE_W=12, CAL_SHIFT=2, DEADBAND=4, ACC_W=32 unless noted.
- Calibration:
  - Stimulus: after reset, feed 4 samples of 2048 to each of ch0–2 (12 samples).
  - Required response: cal_done rises the cycle after the 12th sample; all angles 0; no angle_valid during CAL.
- Integration:
  - Stimulus: in RUN, three samples of 2058 on ch1.
  - Required response: angle_valid pulses with angle_ch=1; ch1 angle goes 10, 20, 30; ch0 and ch2 stay 0.
- Deadband:
  - Stimulus: sample 2050 on ch0 (delta +2).
  - Required response: angle unchanged with IMU_INTEGRATOR_DEADBAND_EN; +2 without it. Sample 2044 (delta −4) also gives 0 with the macro.
- Saturation (ACC_W=16):
  - Stimulus: 17 samples of 4095 on ch2 (delta +2047), then one sample of 0.
  - Required response: ch2 angle saturates at 32767; after the sample of 0 it reads 30719.
- Recalibration:
  - Stimulus: raise no_external_force in the same cycle as a ch0 sample of 3000.
  - Required response: the sample is dropped and cal_done falls; angles are held.
  - Follow-on stimulus: 12 calibration samples of 2000; afterwards, sample 2010 on ch0.
  - Required response: after calibration, all angles 0; the 2010 sample gives ch0 angle 10.
- Reset and invalid channel:
  - Stimulus: assert reset after 2 calibration samples; then send a sample with sample_ch=3.
  - Required response: all outputs are 0 asynchronously on reset; the sample_ch=3 sample has no effect; the full 12 calibration samples are needed again.

Source files
------------

// File: rtl/imu_pkg.sv
// Shared state type, default parameter values and accumulator saturation-limit helper
// for the IMU channel integrator.
package imu_pkg;

  typedef enum logic {
    IMU_CAL = 1'b0,
    IMU_RUN = 1'b1
  } imu_state_e;

  localparam int DEF_NUM_CH    = 3;
  localparam int DEF_SAMPLE_W  = 12;
  localparam int DEF_ACC_W     = 32;
  localparam int DEF_CAL_SHIFT = 8;
  localparam int DEF_DEADBAND  = 4;

  localparam int SAT_MAX_W = 64;

  // Positive (neg=0) or negative (neg=1) rail of a signed acc_w-bit accumulator,
  // in the low acc_w bits of the result.
  function automatic logic [SAT_MAX_W-1:0] sat_limit(input int acc_w, input logic neg);
    logic [SAT_MAX_W-1:0] lim;
    lim = (SAT_MAX_W'(1) << (acc_w - 1)) - SAT_MAX_W'(1);
    return neg ? ~lim : lim;
  endfunction

endpackage

// File: rtl/imu_sat_accumulate.sv
// Signed saturating add of a sign-extended delta into an ACC_W accumulator value.
// Purely combinational; the caller muxes in the channel being updated.
module imu_sat_accumulate
  import imu_pkg::*;
#(
  parameter int ACC_W   = DEF_ACC_W,
  parameter int DELTA_W = DEF_SAMPLE_W + 1
) (
  input  logic signed [ACC_W-1:0]   i_acc,
  input  logic signed [DELTA_W-1:0] i_delta,
  output logic signed [ACC_W-1:0]   o_sum
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_limit(ACC_W, 1'b0));
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_limit(ACC_W, 1'b1));

  logic signed [ACC_W:0] w_wide;

  // One guard bit: overflow shows up as the top two bits disagreeing.
  assign w_wide = $signed({i_acc[ACC_W-1], i_acc}) + (ACC_W + 1)'(i_delta);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    o_sum = w_wide[ACC_W-1:0];
    if (w_wide[ACC_W] != w_wide[ACC_W-1]) begin
      o_sum = w_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

endmodule

// File: rtl/imu_channel_integrator.sv
// Time-multiplexed per-channel offset calibration and saturating rate integration.
// Optional deadband on the corrected rate is enabled by defining IMU_INTEGRATOR_DEADBAND_EN.
module imu_channel_integrator
  import imu_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int SAMPLE_W  = DEF_SAMPLE_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int CAL_SHIFT = DEF_CAL_SHIFT,
  parameter int DEADBAND  = DEF_DEADBAND,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_valid,
  input  logic [CH_W-1:0]         sample_ch,
  input  logic [SAMPLE_W-1:0]     sample_data,
  input  logic                    no_external_force,
  output logic                    cal_done,
  output logic [NUM_CH*ACC_W-1:0] angle_out,
  output logic                    angle_valid,
  output logic [CH_W-1:0]         angle_ch
);

  localparam int SUM_W = SAMPLE_W + CAL_SHIFT;
  localparam int CNT_W = CAL_SHIFT + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1) << CAL_SHIFT;

  if (NUM_CH < 1 || ACC_W < SAMPLE_W + 2 || DEADBAND < 0) begin : g_bad_params
    $error("imu_channel_integrator: invalid parameter set");
  end

  imu_state_e r_state, w_state_next;

  logic                       r_nef_q;
  logic [SUM_W-1:0]           r_sum    [NUM_CH];
  logic [CNT_W-1:0]           r_cnt    [NUM_CH];
  logic [SAMPLE_W-1:0]        r_offset [NUM_CH];
  logic signed [ACC_W-1:0]    r_acc    [NUM_CH];
  logic                       r_angle_valid;
  logic [CH_W-1:0]            r_angle_ch;

  logic                       w_recal;
  logic                       w_ch_ok;
  logic                       w_accept;
  logic [CH_W-1:0]            w_ch_idx;
  logic [SUM_W-1:0]           w_sum_next [NUM_CH];
  logic [CNT_W-1:0]           w_cnt_next [NUM_CH];
  logic                       w_cal_take;
  logic                       w_all_full;
  logic                       w_cal_complete;
  logic signed [SAMPLE_W:0]   w_delta;
  logic signed [SAMPLE_W:0]   w_delta_db;
  logic signed [ACC_W-1:0]    w_acc_sum;

  // A recal edge wins over a coincident sample: the sample is simply dropped.
  assign w_recal  = no_external_force & ~r_nef_q;
  assign w_ch_ok  = (int'(sample_ch) < NUM_CH);
  assign w_accept = sample_valid & w_ch_ok & ~w_recal;
  assign w_ch_idx = w_ch_ok ? sample_ch : '0;

  always_comb begin
    w_cal_take = 1'b0;
    w_all_full = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      w_sum_next[c] = r_sum[c];
      w_cnt_next[c] = r_cnt[c];
      if (r_state == IMU_CAL && w_accept && w_ch_idx == CH_W'(c) && r_cnt[c] != CNT_FULL) begin
        w_sum_next[c] = r_sum[c] + SUM_W'(sample_data);
        w_cnt_next[c] = r_cnt[c] + CNT_W'(1);
        w_cal_take    = 1'b1;
      end
      if (w_cnt_next[c] != CNT_FULL) w_all_full = 1'b0;
    end
  end

  assign w_cal_complete = w_cal_take & w_all_full;

  assign w_delta = $signed({1'b0, sample_data}) - $signed({1'b0, r_offset[w_ch_idx]});

`ifdef IMU_INTEGRATOR_DEADBAND_EN
  localparam logic signed [SAMPLE_W:0] DB_POS = (SAMPLE_W + 1)'(DEADBAND);
  assign w_delta_db = (w_delta <= DB_POS && w_delta >= -DB_POS) ? '0 : w_delta;
`else
  assign w_delta_db = w_delta;
`endif

  imu_sat_accumulate #(
    .ACC_W  (ACC_W),
    .DELTA_W(SAMPLE_W + 1)
  ) u_sat_acc (
    .i_acc  (r_acc[w_ch_idx]),
    .i_delta(w_delta_db),
    .o_sum  (w_acc_sum)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IMU_CAL: if (w_cal_complete) w_state_next = IMU_RUN;
      IMU_RUN: if (w_recal)        w_state_next = IMU_CAL;
      default:                     w_state_next = IMU_CAL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IMU_CAL;
    else       r_state <= w_state_next;
  end

  // NOTE: these register arrays are reset on purpose: offsets, counts and angles must read 0 after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_nef_q       <= 1'b0;
      r_angle_valid <= 1'b0;
      r_angle_ch    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_sum[c]    <= '0;
        r_cnt[c]    <= '0;
        r_offset[c] <= '0;
        r_acc[c]    <= '0;
      end
    end else begin
      r_nef_q       <= no_external_force;
      r_angle_valid <= 1'b0;
      if (w_recal) begin
        for (int c = 0; c < NUM_CH; c++) begin
          r_sum[c] <= '0;
          r_cnt[c] <= '0;
        end
      end else if (r_state == IMU_CAL) begin
        for (int c = 0; c < NUM_CH; c++) begin
          r_sum[c] <= w_sum_next[c];
          r_cnt[c] <= w_cnt_next[c];
          if (w_cal_complete) begin
            r_offset[c] <= SAMPLE_W'(w_sum_next[c] >> CAL_SHIFT);
            r_acc[c]    <= '0;
          end
        end
      end else if (w_accept) begin
        r_acc[w_ch_idx] <= w_acc_sum;
        r_angle_valid   <= 1'b1;
        r_angle_ch      <= sample_ch;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_pack
    assign angle_out[c*ACC_W +: ACC_W] = r_acc[c];
  end

  assign cal_done    = (r_state == IMU_RUN);
  assign angle_valid = r_angle_valid;
  assign angle_ch    = r_angle_ch;

endmodule
